// File: rtl/ec_point_unit_if.sv
// Request/result and engine handshake bundle for ec_point_unit.
// Ports: start/mode/p/a and the operand points in; busy/valid/result out; mul and inv engine req/done pairs.
// The slave modport is the point unit; the master modport is the controller plus the shared engines.
interface ec_point_unit_if #(
    parameter int W = 256
) ();
    logic         i_start;
    logic         i_mode;
    logic [W-1:0] i_p;
    logic [W-1:0] i_a;
    logic [W-1:0] i_x1;
    logic [W-1:0] i_y1;
    logic [W-1:0] i_x2;
    logic [W-1:0] i_y2;
    logic         o_busy;
    logic         o_valid;
    logic [W-1:0] o_x3;
    logic [W-1:0] o_y3;
    logic         o_mul_start;
    logic [W-1:0] o_mul_a;
    logic [W-1:0] o_mul_b;
    logic         i_mul_done;
    logic [W-1:0] i_mul_res;
    logic         o_inv_start;
    logic [W-1:0] o_inv_num;
    logic [W-1:0] o_inv_den;
    logic         i_inv_done;
    logic [W-1:0] i_inv_res;

    modport slave (
        input  i_start, i_mode, i_p, i_a, i_x1, i_y1, i_x2, i_y2,
        input  i_mul_done, i_mul_res, i_inv_done, i_inv_res,
        output o_busy, o_valid, o_x3, o_y3,
        output o_mul_start, o_mul_a, o_mul_b,
        output o_inv_start, o_inv_num, o_inv_den
    );

    modport master (
        output i_start, i_mode, i_p, i_a, i_x1, i_y1, i_x2, i_y2,
        output i_mul_done, i_mul_res, i_inv_done, i_inv_res,
        input  o_busy, o_valid, o_x3, o_y3,
        input  o_mul_start, o_mul_a, o_mul_b,
        input  o_inv_start, o_inv_num, o_inv_den
    );
endinterface

// File: rtl/ec_point_unit.sv
// Elliptic-curve point double / add over GF(p), sequencing a shared modular multiplier and divider.
// Latency: trivial cases (infinity, P==-Q, y==0) give o_valid 3 cycles after start; otherwise set by engine latency.
// Backpressure: none; i_start is ignored (not queued) while o_busy, engine dones are waited on indefinitely.
// Ports: i_clk, i_rst (async, active-high) plus the ec_point_unit_if slave modport:
//   request (i_start, i_mode, i_p, i_a, i_x1/y1, i_x2/y2), result (o_busy, o_valid, o_x3/y3),
//   multiplier (o_mul_start, o_mul_a/b, i_mul_done, i_mul_res), divider (o_inv_start, o_inv_num/den, i_inv_done, i_inv_res).
// Infinity is encoded as x = y = all-ones.
module ec_point_unit #(
    parameter int W = 256
) (
    input  logic           i_clk,
    input  logic           i_rst,
    ec_point_unit_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_CHK, S_NUM, S_DEN, S_INV, S_SQ, S_XC, S_MY, S_YC, S_DONE
    } state_t;

    localparam logic [W-1:0] INF = '1;

    // Modular add of two values already below m: at most two conditional subtractions.
    function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] m);
        logic [W+1:0] s;
        s = {2'b00, x} + {2'b00, y};
        if (s >= {2'b00, m}) s = s - {2'b00, m};
        if (s >= {2'b00, m}) s = s - {2'b00, m};
        return W'(s);
    endfunction

    // Modular subtract of two values already below m: one addition of m on borrow.
    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] m);
        logic [W+1:0] d;
        if (x >= y) d = {2'b00, x} - {2'b00, y};
        else        d = {2'b00, x} + {2'b00, m} - {2'b00, y};
        return W'(d);
    endfunction

    state_t       state_q;
    logic         dbl_q;       // internal mode: 1 = doubling (also set for add with P==Q)
    logic         issued_q;    // current engine request already sent, now waiting for done
    logic [W-1:0] p_q, a_q, x1_q, y1_q, x2_q, y2_q;
    logic [W-1:0] lam_q;
    logic [W-1:0] prod_q;      // last multiplier result (lambda^2, then the y-product)
    logic [W-1:0] x3_q, y3_q;
    logic         busy_q, valid_q;
    logic [W-1:0] out_x3_q, out_y3_q;
    logic         mul_start_q, inv_start_q;
    logic [W-1:0] mul_a_q, mul_b_q, inv_num_q, inv_den_q;

    logic         p_inf, q_inf;
    logic [W-1:0] three_x1_d, num_dbl_d, num_add_d, den_d, x2_eff, x3_d, dx_d, y3_d;

    assign p_inf      = (x1_q == INF) && (y1_q == INF);
    assign q_inf      = (x2_q == INF) && (y2_q == INF);
    assign three_x1_d = mod_add(mod_add(x1_q, x1_q, p_q), x1_q, p_q);
    assign num_dbl_d  = mod_add(bus.i_mul_res, a_q, p_q);
    assign num_add_d  = mod_sub(y2_q, y1_q, p_q);
    assign den_d      = dbl_q ? mod_add(y1_q, y1_q, p_q) : mod_sub(x2_q, x1_q, p_q);
    assign x2_eff     = dbl_q ? x1_q : x2_q;
    assign x3_d       = mod_sub(mod_sub(prod_q, x1_q, p_q), x2_eff, p_q);
    assign dx_d       = mod_sub(x1_q, x3_q, p_q);
    assign y3_d       = mod_sub(prod_q, y1_q, p_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            dbl_q       <= 1'b0;
            issued_q    <= 1'b0;
            p_q         <= '0;
            a_q         <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            x2_q        <= '0;
            y2_q        <= '0;
            lam_q       <= '0;
            prod_q      <= '0;
            x3_q        <= '0;
            y3_q        <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            out_x3_q    <= '0;
            out_y3_q    <= '0;
            mul_start_q <= 1'b0;
            inv_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            inv_num_q   <= '0;
            inv_den_q   <= '0;
        end else begin
            mul_start_q <= 1'b0;
            inv_start_q <= 1'b0;
            valid_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.i_start) begin
                        dbl_q    <= ~bus.i_mode;
                        p_q      <= bus.i_p;
                        a_q      <= bus.i_a;
                        x1_q     <= bus.i_x1;
                        y1_q     <= bus.i_y1;
                        x2_q     <= bus.i_x2;
                        y2_q     <= bus.i_y2;
                        issued_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (p_inf) begin
                        x3_q    <= dbl_q ? INF : x2_q;
                        y3_q    <= dbl_q ? INF : y2_q;
                        state_q <= S_DONE;
                    end else if (!dbl_q && q_inf) begin
                        x3_q    <= x1_q;
                        y3_q    <= y1_q;
                        state_q <= S_DONE;
                    end else if (!dbl_q && (x1_q == x2_q) && (y1_q != y2_q)) begin
                        x3_q    <= INF;
                        y3_q    <= INF;
                        state_q <= S_DONE;
                    end else if (dbl_q || (x1_q == x2_q)) begin
                        // Reaching here with add mode and x1==x2 means P==Q: take the doubling path.
                        dbl_q <= 1'b1;
                        if (y1_q == '0) begin
                            x3_q    <= INF;
                            y3_q    <= INF;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_NUM;
                        end
                    end else begin
                        state_q <= S_NUM;
                    end
                end
                S_NUM: begin
                    if (!dbl_q) begin
                        inv_num_q <= num_add_d;
                        state_q   <= S_DEN;
                    end else if (!issued_q) begin
                        mul_start_q <= 1'b1;
                        mul_a_q     <= three_x1_d;
                        mul_b_q     <= x1_q;
                        issued_q    <= 1'b1;
                    end else if (bus.i_mul_done) begin
                        inv_num_q <= num_dbl_d;
                        issued_q  <= 1'b0;
                        state_q   <= S_DEN;
                    end
                end
                S_DEN: begin
                    inv_den_q <= den_d;
                    state_q   <= S_INV;
                end
                S_INV: begin
                    if (!issued_q) begin
                        inv_start_q <= 1'b1;
                        issued_q    <= 1'b1;
                    end else if (bus.i_inv_done) begin
                        lam_q    <= bus.i_inv_res;
                        issued_q <= 1'b0;
                        state_q  <= S_SQ;
                    end
                end
                S_SQ: begin
                    if (!issued_q) begin
                        mul_start_q <= 1'b1;
                        mul_a_q     <= lam_q;
                        mul_b_q     <= lam_q;
                        issued_q    <= 1'b1;
                    end else if (bus.i_mul_done) begin
                        prod_q   <= bus.i_mul_res;
                        issued_q <= 1'b0;
                        state_q  <= S_XC;
                    end
                end
                S_XC: begin
                    x3_q    <= x3_d;
                    state_q <= S_MY;
                end
                S_MY: begin
                    if (!issued_q) begin
                        mul_start_q <= 1'b1;
                        mul_a_q     <= lam_q;
                        mul_b_q     <= dx_d;
                        issued_q    <= 1'b1;
                    end else if (bus.i_mul_done) begin
                        prod_q   <= bus.i_mul_res;
                        issued_q <= 1'b0;
                        state_q  <= S_YC;
                    end
                end
                S_YC: begin
                    y3_q    <= y3_d;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    out_x3_q <= x3_q;
                    out_y3_q <= y3_q;
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_x3        = out_x3_q;
    assign bus.o_y3        = out_y3_q;
    assign bus.o_mul_start = mul_start_q;
    assign bus.o_mul_a     = mul_a_q;
    assign bus.o_mul_b     = mul_b_q;
    assign bus.o_inv_start = inv_start_q;
    assign bus.o_inv_num   = inv_num_q;
    assign bus.o_inv_den   = inv_den_q;

endmodule

// File: tb/tb_ec_point_unit.sv
// Bench for ec_point_unit with W=8, p=17, a=2 and 5-cycle multiplier/divider models.
module tb_ec_point_unit;
    localparam int W   = 8;
    localparam int P   = 17;
    localparam int A   = 2;
    localparam int INF = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ec_point_unit_if #(.W(W)) bus ();
    ec_point_unit #(.W(W)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int expx[$];
    int expy[$];
    int n_mul, n_inv, mul_cnt, inv_cnt;
    int mul_ca, mul_cb, inv_cn, inv_cd;
    bit mul_abort, inv_abort;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference arithmetic over GF(17) from the curve formulas.
    function automatic int md(input int v);
        return ((v % P) + P) % P;
    endfunction

    function automatic int minv(input int d);
        int r = 1;
        int b = md(d);
        for (int e = 0; e < P - 2; e++) r = (r * b) % P;
        return r;
    endfunction

    task automatic model(input int mode, input int x1, input int y1, input int x2, input int y2,
                         output int rx, output int ry);
        int lam;
        bit dbl;
        dbl = (mode == 0);
        if (x1 == INF && y1 == INF) begin
            rx = dbl ? INF : x2;
            ry = dbl ? INF : y2;
        end else if (!dbl && x2 == INF && y2 == INF) begin
            rx = x1; ry = y1;
        end else if (!dbl && x1 == x2 && y1 != y2) begin
            rx = INF; ry = INF;
        end else begin
            if (!dbl && x1 == x2) dbl = 1;
            if (dbl && y1 == 0) begin
                rx = INF; ry = INF;
            end else begin
                if (dbl) begin
                    lam = md(md(3 * x1 * x1 + A) * minv(2 * y1));
                    x2  = x1;
                end else begin
                    lam = md(md(y2 - y1) * minv(x2 - x1));
                end
                rx = md(lam * lam - x1 - x2);
                ry = md(lam * (x1 - rx) - y1);
            end
        end
    endtask

    // Multiplier engine: done 5 cycles after the start pulse is seen.
    initial begin
        bit prev_start = 0;
        bus.i_mul_done = 1'b0;
        bus.i_mul_res  = '0;
        mul_cnt = 0; n_mul = 0; mul_abort = 0;
        forever begin
            @(posedge clk); #1;
            bus.i_mul_done = 1'b0;
            if (rst) mul_abort = 1;
            if (mul_cnt > 0) begin
                if (!mul_abort) begin
                    chk("mul_a_stable", bus.o_mul_a, mul_ca);
                    chk("mul_b_stable", bus.o_mul_b, mul_cb);
                end
                mul_cnt--;
                if (mul_cnt == 0) begin
                    bus.i_mul_done = 1'b1;
                    bus.i_mul_res  = W'(md(mul_ca * mul_cb));
                end
            end
            if (bus.o_mul_start) begin
                chk("mul_start_width", int'(prev_start), 0);
                chk("mul_start_engines_idle", int'(mul_cnt > 0 || inv_cnt > 0), 0);
                mul_cnt = 5; mul_ca = bus.o_mul_a; mul_cb = bus.o_mul_b;
                mul_abort = 0; n_mul++;
            end
            prev_start = bus.o_mul_start;
        end
    end

    // Divider engine: done 5 cycles after the start pulse is seen.
    initial begin
        bit prev_start = 0;
        bus.i_inv_done = 1'b0;
        bus.i_inv_res  = '0;
        inv_cnt = 0; n_inv = 0; inv_abort = 0;
        forever begin
            @(posedge clk); #1;
            bus.i_inv_done = 1'b0;
            if (rst) inv_abort = 1;
            if (inv_cnt > 0) begin
                if (!inv_abort) begin
                    chk("inv_num_stable", bus.o_inv_num, inv_cn);
                    chk("inv_den_stable", bus.o_inv_den, inv_cd);
                end
                inv_cnt--;
                if (inv_cnt == 0) begin
                    bus.i_inv_done = 1'b1;
                    bus.i_inv_res  = W'(md(inv_cn * minv(inv_cd)));
                end
            end
            if (bus.o_inv_start) begin
                chk("inv_start_width", int'(prev_start), 0);
                chk("inv_start_engines_idle", int'(mul_cnt > 0 || inv_cnt > 0), 0);
                inv_cnt = 5; inv_cn = bus.o_inv_num; inv_cd = bus.o_inv_den;
                inv_abort = 0; n_inv++;
            end
            prev_start = bus.o_inv_start;
        end
    end

    // Result checker: every valid against the model queue, held result otherwise.
    initial begin
        int last_x = 0, last_y = 0, ex, ey;
        bit prev_valid = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                last_x = 0; last_y = 0; prev_valid = 0;
            end else begin
                if (bus.o_valid) begin
                    chk("valid_width", int'(prev_valid), 0);
                    chk("busy_low_at_valid", bus.o_busy, 0);
                    if (expx.size() == 0) begin
                        chk("valid_without_request", bus.o_valid, 0);
                    end else begin
                        ex = expx.pop_front();
                        ey = expy.pop_front();
                        chk("result_x3", bus.o_x3, ex);
                        chk("result_y3", bus.o_y3, ey);
                    end
                end else begin
                    chk("x3_held", bus.o_x3, last_x);
                    chk("y3_held", bus.o_y3, last_y);
                end
                last_x = bus.o_x3; last_y = bus.o_y3;
                prev_valid = bus.o_valid;
            end
        end
    end

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, bus.o_valid, 0);
        chk({nm, "_busy"}, bus.o_busy, 0);
        chk({nm, "_x3"}, bus.o_x3, 0);
        chk({nm, "_y3"}, bus.o_y3, 0);
        chk({nm, "_mul_start"}, bus.o_mul_start, 0);
        chk({nm, "_mul_a"}, bus.o_mul_a, 0);
        chk({nm, "_mul_b"}, bus.o_mul_b, 0);
        chk({nm, "_inv_start"}, bus.o_inv_start, 0);
        chk({nm, "_inv_num"}, bus.o_inv_num, 0);
        chk({nm, "_inv_den"}, bus.o_inv_den, 0);
    endtask

    task automatic drive_start(input int mode, input int x1, input int y1, input int x2, input int y2);
        bus.i_start = 1'b1;
        bus.i_mode  = mode[0];
        bus.i_x1 = W'(x1); bus.i_y1 = W'(y1);
        bus.i_x2 = W'(x2); bus.i_y2 = W'(y2);
    endtask

    // Called at a negedge; returns at the negedge after the result cycle.
    task automatic run_op(input string nm, input int mode, input int x1, input int y1,
                          input int x2, input int y2, input int ex, input int ey,
                          input int emul, input int einv, input bit chk_lat, input bit intrude);
        int rx, ry, t0;
        bit seen = 0;
        model(mode, x1, y1, x2, y2, rx, ry);
        chk({nm, "_model_x"}, rx, ex);
        chk({nm, "_model_y"}, ry, ey);
        expx.push_back(rx);
        expy.push_back(ry);
        n_mul = 0; n_inv = 0;
        drive_start(mode, x1, y1, x2, y2);
        t0 = cyc;
        @(negedge clk);
        bus.i_start = 1'b0;
        chk({nm, "_busy"}, bus.o_busy, 1);
        for (int i = 0; i < 300; i++) begin
            if (bus.o_valid) begin
                seen = 1;
                break;
            end
            bus.i_start = 1'b0;
            if (intrude && i == 3) drive_start(1, 6, 3, 10, 6);
            @(negedge clk);
        end
        bus.i_start = 1'b0;
        chk({nm, "_valid_seen"}, int'(seen), 1);
        if (chk_lat) chk({nm, "_latency"}, cyc - t0, 3);
        chk({nm, "_mul_reqs"}, n_mul, emul);
        chk({nm, "_inv_reqs"}, n_inv, einv);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found = 0;
        bus.i_start = 1'b0; bus.i_mode = 1'b0;
        bus.i_p = W'(P); bus.i_a = W'(A);
        bus.i_x1 = '0; bus.i_y1 = '0; bus.i_x2 = '0; bus.i_y2 = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_op("dbl_5_1",     0, 5, 1, 0, 0,      6, 3,     3, 1, 0, 0);
        run_op("add_5_1_6_3", 1, 5, 1, 6, 3,      10, 6,    2, 1, 0, 0);
        run_op("add_neg",     1, 5, 1, 5, 16,     INF, INF, 0, 0, 1, 0);
        run_op("add_same",    1, 5, 1, 5, 1,      6, 3,     3, 1, 0, 0);
        run_op("add_p_inf",   1, INF, INF, 6, 3,  6, 3,     0, 0, 1, 0);
        run_op("add_q_inf",   1, 6, 3, INF, INF,  6, 3,     0, 0, 1, 0);
        run_op("dbl_inf",     0, INF, INF, 0, 0,  INF, INF, 0, 0, 1, 0);
        run_op("dbl_y0",      0, 3, 0, 0, 0,      INF, INF, 0, 0, 1, 0);
        run_op("busy_start",  0, 5, 1, 0, 0,      6, 3,     3, 1, 0, 1);
        repeat (5) @(negedge clk);

        // Reset while the divider request is outstanding.
        drive_start(0, 5, 1, 0, 0);
        @(negedge clk);
        bus.i_start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.o_inv_start) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_inv_start_seen", int'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_valid", bus.o_valid, 0);
            chk("post_rst_busy", bus.o_busy, 0);
        end
        run_op("after_rst",   0, 5, 1, 0, 0,      6, 3,     3, 1, 0, 0);

        repeat (10) @(negedge clk);
        chk("results_pending", expx.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
